// File: rtl/onehot_decoder_2to4_pulse.sv
// Sequential 2-to-4 decoder with pulse stretching.
// Takes an encoded index {in_en, in_code} over a valid/ready handshake.
// It drives the matching one-hot line on Y for PULSE_LEN cycles.
// It then gives a one-cycle done strobe.
// Optional feature macro: ONEHOT_DEC_SKID_EN. It adds a one-entry skid buffer.
// With the buffer, back-to-back pulses run with no idle cycle between them.
module onehot_decoder_2to4_pulse #(
    parameter int unsigned PULSE_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_code,
    input  logic       in_en,
    output logic [3:0] Y,
    output logic       busy,
    output logic       done
);

    typedef enum logic [0:0] {StIdle, StPulse} state_e;

    localparam logic [7:0] CntLoad = 8'(PULSE_LEN - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] y_q, y_d;
    logic       done_q, done_d;
    logic       accept;

    function automatic logic [3:0] dec(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

`ifdef ONEHOT_DEC_SKID_EN
    logic       skid_full_q, skid_full_d;
    logic       skid_en_q, skid_en_d;
    logic [1:0] skid_code_q, skid_code_d;
    logic       nxt_valid, nxt_en;
    logic [1:0] nxt_code;

    // Ready depends only on buffer space, so a transaction can arrive during a pulse.
    assign in_ready = rst_n & ~skid_full_q;

    // Skid buffer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_full_q <= 1'b0;
            skid_en_q   <= 1'b0;
            skid_code_q <= 2'b00;
        end else begin
            skid_full_q <= skid_full_d;
            skid_en_q   <= skid_en_d;
            skid_code_q <= skid_code_d;
        end
    end
`else
    assign in_ready = rst_n & (state_q == StIdle);
`endif

    assign accept = in_valid & in_ready;
    assign Y      = y_q;
    assign busy   = (state_q == StPulse);
    assign done   = done_q;

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            y_q     <= 4'b0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: load on accept, count down, then finish or chain
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        done_d  = 1'b0;
`ifdef ONEHOT_DEC_SKID_EN
        skid_full_d = skid_full_q;
        skid_en_d   = skid_en_q;
        skid_code_d = skid_code_q;
        // The buffered entry takes priority.
        // Otherwise, an accept on the final edge is chained directly.
        nxt_valid   = skid_full_q | accept;
        nxt_en      = skid_full_q ? skid_en_q : in_en;
        nxt_code    = skid_full_q ? skid_code_q : in_code;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (in_en) begin
                        y_d     = dec(in_code);
                        cnt_d   = CntLoad;
                        state_d = StPulse;
                    end else begin
                        // A null transaction completes at once without driving any line.
                        done_d = 1'b1;
                    end
                end
            end
            StPulse: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
`ifdef ONEHOT_DEC_SKID_EN
                    if (accept) begin
                        skid_full_d = 1'b1;
                        skid_en_d   = in_en;
                        skid_code_d = in_code;
                    end
`endif
                end else begin
                    done_d = 1'b1;
`ifdef ONEHOT_DEC_SKID_EN
                    skid_full_d = 1'b0;
                    if (nxt_valid && nxt_en) begin
                        y_d   = dec(nxt_code);
                        cnt_d = CntLoad;
                    end else begin
                        y_d     = 4'b0000;
                        state_d = StIdle;
                    end
`else
                    y_d     = 4'b0000;
                    state_d = StIdle;
`endif
                end
            end
            default: begin
                state_d = StIdle;
                y_d     = 4'b0000;
            end
        endcase
    end

endmodule

// File: tb/tb_onehot_decoder_2to4_pulse.sv
// Directed table-driven bench for onehot_decoder_2to4_pulse.
// It drives one shared stimulus into instances with different PULSE_LEN values.
// Each test checks only the instance it targets.
// The skid-buffer sequence is built only when ONEHOT_DEC_SKID_EN is defined.
module tb_onehot_decoder_2to4_pulse;

    typedef struct {
        logic       valid;
        logic       en;
        logic [1:0] code;
        logic [3:0] y;
        logic       busy;
        logic       done;
        logic       ready;
    } vec_t;

`ifdef ONEHOT_DEC_SKID_EN
    localparam logic RP = 1'b1;  // ready during a pulse while buffer is empty
`else
    localparam logic RP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_en = 1'b0;
    logic [1:0] in_code = 2'b00;

    logic [3:0] y4, y2, y1, y3;
    logic       b4, b2, b1, b3, d4, d2, d1, d3, r4, r2, r1, r3;

    int total = 0;
    int bad = 0;
    vec_t tq[$];

    always #5 clk = ~clk;

    onehot_decoder_2to4_pulse #(.PULSE_LEN(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r4),
        .in_code(in_code), .in_en(in_en), .Y(y4), .busy(b4), .done(d4)
    );
    onehot_decoder_2to4_pulse #(.PULSE_LEN(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r2),
        .in_code(in_code), .in_en(in_en), .Y(y2), .busy(b2), .done(d2)
    );
    onehot_decoder_2to4_pulse #(.PULSE_LEN(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1),
        .in_code(in_code), .in_en(in_en), .Y(y1), .busy(b1), .done(d1)
    );
    onehot_decoder_2to4_pulse #(.PULSE_LEN(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r3),
        .in_code(in_code), .in_en(in_en), .Y(y3), .busy(b3), .done(d3)
    );

    function automatic vec_t mk(logic v, logic e, logic [1:0] c, logic [3:0] y,
                                logic b, logic d, logic r);
        vec_t t;
        t.valid = v; t.en = e; t.code = c; t.y = y; t.busy = b; t.done = d; t.ready = r;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [3:0] got,
                       input logic [3:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d] got=%b want=%b", nm, idx, got, want);
        end
    endtask

    task automatic chk_outs(input int sel, input string nm, input int idx,
                            input logic [3:0] y, input logic b, input logic d, input logic r);
        logic [3:0] gy;
        logic gb, gd, gr;
        case (sel)
            4: begin gy = y4; gb = b4; gd = d4; gr = r4; end
            2: begin gy = y2; gb = b2; gd = d2; gr = r2; end
            1: begin gy = y1; gb = b1; gd = d1; gr = r1; end
            default: begin gy = y3; gb = b3; gd = d3; gr = r3; end
        endcase
        chk({nm, ".Y"}, idx, gy, y);
        chk({nm, ".busy"}, idx, {3'b0, gb}, {3'b0, b});
        chk({nm, ".done"}, idx, {3'b0, gd}, {3'b0, d});
        chk({nm, ".ready"}, idx, {3'b0, gr}, {3'b0, r});
    endtask

    // Inputs change on the falling edge; outputs are checked 1 after the rising edge.
    task automatic run_tab(input int sel, input string nm);
        for (int i = 0; i < tq.size(); i++) begin
            @(negedge clk);
            in_valid = tq[i].valid;
            in_en    = tq[i].en;
            in_code  = tq[i].code;
            @(posedge clk);
            #1;
            chk_outs(sel, nm, i, tq[i].y, tq[i].busy, tq[i].done, tq[i].ready);
        end
        tq.delete();
    endtask

    task automatic do_reset(input int sel, input string nm);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_outs(sel, {nm, ".rst"}, 0, 4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_outs(sel, {nm, ".rel"}, 0, 4'b0000, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // Main PULSE_LEN=4 sequence: en=1 code=2 pulse, null accept, ignored input changes
        do_reset(4, "main");
        tq.push_back(mk(1, 1, 2, 4'b0100, 1, 0, RP));
        tq.push_back(mk(0, 0, 0, 4'b0100, 1, 0, RP));
        tq.push_back(mk(0, 0, 0, 4'b0100, 1, 0, RP));
        tq.push_back(mk(0, 0, 0, 4'b0100, 1, 0, RP));
        tq.push_back(mk(0, 0, 0, 4'b0000, 0, 1, 1));
        tq.push_back(mk(1, 0, 3, 4'b0000, 0, 1, 1));
        tq.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 1));
        tq.push_back(mk(1, 1, 1, 4'b0010, 1, 0, RP));
        tq.push_back(mk(0, 1, 3, 4'b0010, 1, 0, RP));
        tq.push_back(mk(0, 0, 0, 4'b0010, 1, 0, RP));
        tq.push_back(mk(0, 1, 2, 4'b0010, 1, 0, RP));
        tq.push_back(mk(0, 1, 2, 4'b0000, 0, 1, 1));
        tq.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 1));
        run_tab(4, "main");

        // Asynchronous reset mid-pulse (Y=1000, counter=2), then a full pulse afterwards
        do_reset(4, "arst");
        tq.push_back(mk(1, 1, 3, 4'b1000, 1, 0, RP));
        tq.push_back(mk(0, 0, 0, 4'b1000, 1, 0, RP));
        run_tab(4, "arst_pre");
        #3;
        rst_n = 1'b0;
        #1;
        chk_outs(4, "arst_now", 0, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tq.push_back(mk(1, 1, 1, 4'b0010, 1, 0, RP));
        tq.push_back(mk(0, 0, 0, 4'b0010, 1, 0, RP));
        tq.push_back(mk(0, 0, 0, 4'b0010, 1, 0, RP));
        tq.push_back(mk(0, 0, 0, 4'b0010, 1, 0, RP));
        tq.push_back(mk(0, 0, 0, 4'b0000, 0, 1, 1));
        run_tab(4, "arst_post");

        // PULSE_LEN=1: single-cycle pulse
        do_reset(1, "len1");
        tq.push_back(mk(1, 1, 0, 4'b0001, 1, 0, RP));
        tq.push_back(mk(0, 0, 0, 4'b0000, 0, 1, 1));
        tq.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 1));
        run_tab(1, "len1");

`ifndef ONEHOT_DEC_SKID_EN
        // PULSE_LEN=2 with in_valid held high: codes 0,1,3 back-to-back
        do_reset(2, "b2b");
        tq.push_back(mk(1, 1, 0, 4'b0001, 1, 0, 0));
        tq.push_back(mk(1, 1, 1, 4'b0001, 1, 0, 0));
        tq.push_back(mk(1, 1, 1, 4'b0000, 0, 1, 1));
        tq.push_back(mk(1, 1, 1, 4'b0010, 1, 0, 0));
        tq.push_back(mk(1, 1, 3, 4'b0010, 1, 0, 0));
        tq.push_back(mk(1, 1, 3, 4'b0000, 0, 1, 1));
        tq.push_back(mk(1, 1, 3, 4'b1000, 1, 0, 0));
        tq.push_back(mk(0, 0, 0, 4'b1000, 1, 0, 0));
        tq.push_back(mk(0, 0, 0, 4'b0000, 0, 1, 1));
        run_tab(2, "b2b");
`else
        // PULSE_LEN=3 with skid: {1,0}, then {1,3} buffered, seamless switch
        do_reset(3, "skid");
        tq.push_back(mk(1, 1, 0, 4'b0001, 1, 0, 1));
        tq.push_back(mk(1, 1, 3, 4'b0001, 1, 0, 0));
        tq.push_back(mk(0, 0, 0, 4'b0001, 1, 0, 0));
        tq.push_back(mk(0, 0, 0, 4'b1000, 1, 1, 1));
        tq.push_back(mk(0, 0, 0, 4'b1000, 1, 0, 1));
        tq.push_back(mk(0, 0, 0, 4'b1000, 1, 0, 1));
        tq.push_back(mk(0, 0, 0, 4'b0000, 0, 1, 1));
        tq.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 1));
        run_tab(3, "skid");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
